// File: rtl/mix_pkg.sv
// rtl/mix_pkg.sv - shared lane/block types, FSM states, scaling constants and pack helpers
//
// Used by mix_round and mix_round_sequencer.
// K/C are consumed only when MIX_FINAL_SCALE_EN is defined.
package mix_pkg;

  localparam int NLANES = 8;
  localparam int LANE_W = 32;
  localparam int BLK_W  = NLANES * LANE_W;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [NLANES-1:0] block_t;

  typedef enum logic [1:0] {IDLE, RUN, SCALE, DONE} state_t;

  // Final scaling: o[i] = o[i]*K[i] + C[i]
  localparam lane_t K [NLANES] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam lane_t C [NLANES] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};

  // Lane i occupies bits [32i+31:32i] of the flat vector
  function automatic logic [BLK_W-1:0] pack_block(input block_t b);
    logic [BLK_W-1:0] v;
    v = '0;
    for (int i = 0; i < NLANES; i++) v[i*LANE_W +: LANE_W] = b[i];
    return v;
  endfunction

  function automatic block_t unpack_block(input logic [BLK_W-1:0] v);
    block_t b;
    b = '0;
    for (int i = 0; i < NLANES; i++) b[i] = v[i*LANE_W +: LANE_W];
    return b;
  endfunction

endpackage

// File: rtl/mix_round.sv
// rtl/mix_round.sv - one combinational mixing round over 8 x 32-bit lanes
//
// Ports:
//   blk_in   block_t  lane state before the round
//   blk_out  block_t  lane state after phases A, B, C
module mix_round
  import mix_pkg::*;
(
  input  block_t blk_in,
  output block_t blk_out
);

  block_t o;

  // Each phase updates lanes in place in order 0..7, so lane i sees
  // already-updated values for lower indices (wrapping at 8).
  always_comb begin
    o = blk_in;
    for (int i = 0; i < NLANES; i++)
      o[i] = o[i] + o[3'(i + 1)] - o[3'(i + 5)];
    for (int i = 0; i < NLANES; i++)
      o[i] = o[i] ^ (o[3'(i + 3)] << 16);
    for (int i = 0; i < NLANES; i++)
      o[i] = o[i] - (o[3'(i + 2)] >> 17) + (o[3'(i + 4)] >> 12);
    blk_out = o;
  end

endmodule

// File: rtl/mix_round_sequencer.sv
// rtl/mix_round_sequencer.sv - iterative NROUNDS-round mixing engine with valid/ready in and out
//
// Optional feature macro: MIX_FINAL_SCALE_EN (adds a one-cycle SCALE state).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     seed handshake (ready only in IDLE)
//   in_data[255:0]        seed, lane i = bits [32i+31:32i]
//   out_valid/out_ready   result handshake (valid only in DONE)
//   out_data[255:0]       result lanes, same packing
//   flush                 synchronous abort to IDLE, highest priority
//   busy                  high in RUN or SCALE
//   round_idx[7:0]        current round number
//   blk_cnt[CNT_W-1:0]    completed output handshakes, wrapping
module mix_round_sequencer
  import mix_pkg::*;
#(
  parameter int NROUNDS = 12,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [255:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_data,
  input  logic             flush,
  output logic             busy,
  output logic [7:0]       round_idx,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam logic [7:0] LAST_ROUND = 8'(NROUNDS - 1);

  state_t           state, state_d;
  block_t           lanes, mixed, load_blk;
  logic [7:0]       round_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_round;

  mix_round u_round (
    .blk_in  (lanes),
    .blk_out (mixed)
  );

  assign last_round = (round_q == LAST_ROUND);

  // Seed load adds the lane index so an all-zero seed still mixes.
  always_comb begin
    load_blk = unpack_block(in_data);
    for (int i = 0; i < NLANES; i++) load_blk[i] = load_blk[i] + LANE_W'(i);
  end

`ifdef MIX_FINAL_SCALE_EN
  block_t final_blk;
  always_comb begin
    final_blk = lanes;
    for (int i = 0; i < NLANES; i++) final_blk[i] = lanes[i] * K[i] + C[i];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (in_valid) state_d = RUN;
`ifdef MIX_FINAL_SCALE_EN
      RUN:   if (last_round) state_d = SCALE;
      SCALE: state_d = DONE;
`else
      RUN:   if (last_round) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Lane contents are left untouched on flush; they are reloaded on the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes   <= '0;
      round_q <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      round_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          lanes   <= load_blk;
          round_q <= '0;
        end
        RUN: begin
          lanes   <= mixed;
          round_q <= last_round ? 8'd0 : round_q + 8'd1;
        end
`ifdef MIX_FINAL_SCALE_EN
        SCALE: lanes <= final_blk;
`endif
        DONE: if (out_ready) cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == SCALE);
  assign out_data  = pack_block(lanes);
  assign round_idx = round_q;
  assign blk_cnt   = cnt_q;

endmodule

// File: doc/mix_round_sequencer.md
Name: mix_round_sequencer

Overview:
- Iterative controller for the 8-lane, 32-bit mixing datapath.
- Accepts one 8-word seed block over a valid/ready handshake.
- Applies NROUNDS mixing rounds to that block, one round per clock, then presents the result over a valid/ready handshake.
- Sits between a block producer and consumer and replaces the unrolled single-cycle computation with a sequenced, area-shared round engine.

Parameters:
- NROUNDS, 12, number of rounds per block; legal range 1..255.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  seed block valid.
- in_ready  out  1  sequencer can accept a seed (state IDLE).
- in_data  in  256  seed; lane i = in_data[32i+31:32i].
- out_valid  out  1  result valid (state DONE).
- out_ready  in  1  consumer accepts result.
- out_data  out  256  result lanes; same packing as in_data.
- flush  in  1  synchronous abort to IDLE.
- busy  out  1  high in RUN or SCALE.
- round_idx  out  8  current round number, 0..NROUNDS-1.
- blk_cnt  out  CNT_W  count of completed output handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; lanes, round_idx, blk_cnt cleared to 0; in_ready=1, out_valid=0, busy=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, go to RUN. Load lane[i] = seed_i + i (mod 2^32) and set round_idx=0.
  - RUN: each cycle, lane <= round(lane) and round_idx increments. When the round with round_idx==NROUNDS-1 executes, go to DONE (or to SCALE when MIX_FINAL_SCALE_EN is defined) and round_idx returns to 0.
  - SCALE: one cycle; applies the final scaling, then go to DONE.
  - DONE: out_valid=1 and out_data=lanes, both stable until accepted. On out_valid&&out_ready, blk_cnt increments and state goes to IDLE. A new seed is not accepted in the same cycle; at most one block per NROUNDS+2 cycles.
- Round function (combinational):
  - All arithmetic is 32-bit unsigned modulo 2^32, indices mod 8.
  - Lanes are updated in place in order 0..7, so later lanes use already-updated values.
  - Phase A: o[i] = o[i] + o[i+1] - o[i+5].
  - Phase B: o[i] = o[i] ^ (o[i+3] << 16).
  - Phase C: o[i] = o[i] - (o[i+2] >> 17) + (o[i+4] >> 12). Shifts are logical.
- Latency: out_valid rises NROUNDS cycles after the accepting edge, or NROUNDS+1 cycles with scaling.
- flush:
  - Has priority over every other transition in all states: next state is IDLE, round_idx=0, out_valid=0, blk_cnt unchanged, lanes are don't-care.
  - flush together with in_valid in IDLE: no accept.
- Reset mid-operation: immediate return to the reset state; the partial block is discarded.
- out_ready held low in DONE: the sequencer holds indefinitely and in_ready stays 0.

Optional Feature:
- Macro: MIX_FINAL_SCALE_EN.
- Defined: SCALE state is present. It computes o[i] = o[i]*K[i] + C[i] (mod 2^32) with K = {2,3,5,7,11,13,17,19} and C = {3,5,7,11,13,17,19,23}.
- Undefined: no SCALE state; RUN goes directly to DONE; no multipliers are synthesized.

Decomposition:
- Package mix_pkg holds:
  - NLANES=8 and LANE_W=32.
  - lane_t and block_t (array of 8 lane_t).
  - State enum {IDLE, RUN, SCALE, DONE}.
  - K and C constant arrays.
  - Functions pack/unpack between block_t and 256-bit vectors.
- One sub-module, mix_round: purely combinational, block_t in, block_t out, implements phases A-C. The sequencer holds all registers and the FSM.

Test Plan:
- Reset/idle: assert rst mid-RUN (round_idx=5) -> all outputs return to the reset values asynchronously; in_ready=1, out_valid=0, blk_cnt=0.
- Load check, NROUNDS=1, all-zero seed: the lane state before the round must be {0,1,2,3,4,5,6,7}. After one round, out_data must match the bench model, including lane0=0x00047F73. out_valid rises 1 cycle after the accept edge (2 with scaling).
- Default NROUNDS=12 with random seeds, 100 blocks, out_ready always 1:
  - out_data matches the bench model of the unrolled computation.
  - Handshakes are spaced exactly 14 cycles apart (15 with scaling).
  - blk_cnt=100 at the end.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0. Release -> one handshake and blk_cnt+1.
- flush in RUN at round_idx=3 -> next cycle IDLE, in_ready=1, no out_valid, blk_cnt unchanged. flush with in_valid in IDLE -> no accept.
- blk_cnt wrap, CNT_W=4: complete 17 blocks -> blk_cnt=1.
